flb_dlf: RTL and testbench

FLB_DLF -- requirements
Module: flb_dlf

---
 rtl/flb_dlf.sv | 193 +++++++++++++++++++
 tb/tb_flb_dlf.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/flb_dlf.sv
// flb_dlf: proportional-integral digital loop filter producing the oscillator code.
// Optional lock detector and TRACK state enabled by macro FLB_DLF_LOCK_DET_EN.
module flb_dlf #(
   parameter int DLF_W    = 16,
   parameter int ERR_W    = 12,
   parameter int LOCK_CNT = 64,
   parameter int LOCK_THR = 4
) (
   input  logic             ref_clk,
   input  logic             rst_n,
   input  logic             csr_dlf_en,
   input  logic             csr_hold,
   input  logic [3:0]       csr_kp_shift,
   input  logic [3:0]       csr_ki_shift,
   input  logic [DLF_W-1:0] csr_init_code,
   input  logic [ERR_W-1:0] err,
   input  logic             err_vld,
   output logic [DLF_W-1:0] dlf_out,
   output logic             dlf_vld,
   output logic [1:0]       dlf_state,
   output logic             lock
);

   localparam int AW = DLF_W + 8;
   localparam int SW = DLF_W + 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACQ   = 2'd1,
      TRACK = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [DLF_W-1:0]  out_q, out_d;
   logic              vld_q, vld_d;
   logic              lock_q, lock_d;

   logic [3:0]        kp_eff, ki_eff;
   logic signed [SW-1:0] err_s, i_inc, p_term;
   logic signed [SW-1:0] acc_sum, out_sum, out_shr;
   logic [AW-1:0]     acc_new;
   logic [DLF_W-1:0]  out_new;
   logic [AW-1:0]     init_acc;

`ifdef FLB_DLF_LOCK_DET_EN
   localparam int CW = $clog2(LOCK_CNT + 1);
   logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
   logic [ERR_W:0]    err_ext, err_abs;
   logic              in_win, out_win;

   // Error magnitude and lock/unlock window tests
   always_comb begin
      err_ext = {err[ERR_W-1], err};
      err_abs = err_ext[ERR_W] ? (~err_ext + 1'b1) : err_ext;
      in_win  = err_abs <= (ERR_W+1)'(LOCK_THR);
      out_win = err_abs > (ERR_W+1)'(4 * LOCK_THR);
      cnt_inc = (cnt_q == CW'(LOCK_CNT)) ? cnt_q : cnt_q + 1'b1;
   end
`endif

   // Gain selection and saturating PI arithmetic
   always_comb begin
      kp_eff = csr_kp_shift;
      ki_eff = csr_ki_shift;
      if (state_q == TRACK) begin
         kp_eff = (csr_kp_shift > 4'd13) ? 4'd15 : csr_kp_shift + 4'd2;
         ki_eff = (csr_ki_shift > 4'd13) ? 4'd15 : csr_ki_shift + 4'd2;
      end
      err_s   = {{(SW-ERR_W-8){err[ERR_W-1]}}, err, 8'd0};
      i_inc   = err_s >>> ki_eff;
      p_term  = err_s >>> kp_eff;
      acc_sum = $signed({2'b00, acc_q}) + i_inc;
      out_sum = acc_sum + p_term;
      out_shr = out_sum >>> 8;
      if (acc_sum[SW-1])
         acc_new = '0;
      else if (|acc_sum[SW-2:AW])
         acc_new = '1;
      else
         acc_new = acc_sum[AW-1:0];
      if (out_shr[SW-1])
         out_new = '0;
      else if (|out_shr[SW-2:DLF_W])
         out_new = '1;
      else
         out_new = out_shr[DLF_W-1:0];
      init_acc = {csr_init_code, 8'd0};
   end

   // Next-state and datapath update decisions
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      out_d   = out_q;
      vld_d   = 1'b0;
      lock_d  = lock_q;
`ifdef FLB_DLF_LOCK_DET_EN
      cnt_d   = cnt_q;
`endif
      if (!csr_dlf_en) begin
         state_d = IDLE;
         acc_d   = init_acc;
         out_d   = csr_init_code;
         lock_d  = 1'b0;
`ifdef FLB_DLF_LOCK_DET_EN
         cnt_d   = '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               acc_d  = init_acc;
               out_d  = csr_init_code;
               lock_d = 1'b0;
`ifdef FLB_DLF_LOCK_DET_EN
               cnt_d  = '0;
`endif
               if (!csr_hold) state_d = ACQ;
            end
            HOLD: begin
               if (!csr_hold) begin
                  state_d = ACQ;
                  lock_d  = 1'b0;
`ifdef FLB_DLF_LOCK_DET_EN
                  cnt_d   = '0;
`endif
               end
            end
            ACQ, TRACK: begin
               if (csr_hold) begin
                  state_d = HOLD;
               end else if (err_vld) begin
                  acc_d = acc_new;
                  out_d = out_new;
                  vld_d = 1'b1;
`ifdef FLB_DLF_LOCK_DET_EN
                  if (state_q == ACQ) begin
                     if (in_win) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(LOCK_CNT)) begin
                           state_d = TRACK;
                           lock_d  = 1'b1;
                        end
                     end else begin
                        cnt_d = '0;
                     end
                  end else if (out_win) begin
                     state_d = ACQ;
                     lock_d  = 1'b0;
                     cnt_d   = '0;
                  end
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= AW'(1) << (AW - 1);
         out_q   <= DLF_W'(1) << (DLF_W - 1);
         vld_q   <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         lock_q  <= lock_d;
      end
   end

`ifdef FLB_DLF_LOCK_DET_EN
   // Consecutive in-window sample counter
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
   assign lock = lock_q;
`else
   assign lock = 1'b0;
`endif

   assign dlf_out   = out_q;
   assign dlf_vld   = vld_q;
   assign dlf_state = state_q;

endmodule

// File: tb/tb_flb_dlf.sv
// tb_flb_dlf: directed vector table plus multi-cycle sequences for flb_dlf.
// Lock sequences follow FLB_DLF_LOCK_DET_EN.
module tb_flb_dlf;

   logic        ref_clk = 1'b0;
   logic        rst_n;
   logic        csr_dlf_en;
   logic        csr_hold;
   logic [3:0]  csr_kp_shift;
   logic [3:0]  csr_ki_shift;
   logic [15:0] csr_init_code;
   logic [11:0] err;
   logic        err_vld;
   logic [15:0] dlf_out;
   logic        dlf_vld;
   logic [1:0]  dlf_state;
   logic        lock;

   int checks = 0;
   int errors = 0;

   flb_dlf dut (
      .ref_clk(ref_clk), .rst_n(rst_n),
      .csr_dlf_en(csr_dlf_en), .csr_hold(csr_hold),
      .csr_kp_shift(csr_kp_shift), .csr_ki_shift(csr_ki_shift),
      .csr_init_code(csr_init_code),
      .err(err), .err_vld(err_vld),
      .dlf_out(dlf_out), .dlf_vld(dlf_vld),
      .dlf_state(dlf_state), .lock(lock)
   );

   always #5 ref_clk = ~ref_clk;

   typedef struct {
      logic [15:0] init;
      logic [3:0]  kp;
      logic [3:0]  ki;
      logic [11:0] e;
      logic [15:0] exp_out;
      logic [23:0] exp_acc;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge ref_clk);
      #1;
   endtask

   // Restart from IDLE with a new init code, then enter ACQ
   task automatic restart(input logic [15:0] init, input logic [3:0] kp,
                          input logic [3:0] ki);
      csr_init_code = init;
      csr_kp_shift  = kp;
      csr_ki_shift  = ki;
      csr_hold      = 1'b0;
      err_vld       = 1'b0;
      csr_dlf_en    = 1'b0;
      step();
      csr_dlf_en = 1'b1;
      step();
   endtask

   task automatic sample(input logic [11:0] e);
      err     = e;
      err_vld = 1'b1;
      step();
      err_vld = 1'b0;
   endtask

   initial begin
      vecs[0] = '{16'h8000, 4'd2,  4'd6,  12'h040, 16'h8011, 24'h800100};
      vecs[1] = '{16'hFFF0, 4'd0,  4'd0,  12'h7FF, 16'hFFFF, 24'hFFFFFF};
      vecs[2] = '{16'h0010, 4'd0,  4'd0,  12'h800, 16'h0000, 24'h000000};
      vecs[3] = '{16'h1000, 4'd4,  4'd8,  12'hF00, 16'h0FEF, 24'h0FFF00};
      vecs[4] = '{16'h4000, 4'd15, 4'd15, 12'h001, 16'h4000, 24'h400000};
      vecs[5] = '{16'h4000, 4'd15, 4'd15, 12'hFFF, 16'h3FFF, 24'h3FFFFF};
      vecs[6] = '{16'h0000, 4'd0,  4'd1,  12'h003, 16'h0004, 24'h000180};
      vecs[7] = '{16'hFFFF, 4'd1,  4'd3,  12'h064, 16'hFFFF, 24'hFFFFFF};

      rst_n = 1'b0;
      csr_dlf_en = 1'b0;
      csr_hold = 1'b0;
      csr_kp_shift = 4'd0;
      csr_ki_shift = 4'd0;
      csr_init_code = 16'h1234;
      err = '0;
      err_vld = 1'b0;
      #12;
      chk("rst_out",   32'(dlf_out),   32'h8000);
      chk("rst_state", 32'(dlf_state), 32'd0);
      chk("rst_lock",  32'(lock),      32'd0);
      chk("rst_vld",   32'(dlf_vld),   32'd0);
      chk("rst_acc",   32'(dut.acc_q), 32'h800000);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         restart(vecs[i].init, vecs[i].kp, vecs[i].ki);
         chk($sformatf("v%0d_idle_out", i), 32'(dlf_out), 32'(vecs[i].init));
         chk($sformatf("v%0d_novld", i), 32'(dlf_vld), 32'd0);
         sample(vecs[i].e);
         chk($sformatf("v%0d_out", i), 32'(dlf_out), 32'(vecs[i].exp_out));
         chk($sformatf("v%0d_acc", i), 32'(dut.acc_q), 32'(vecs[i].exp_acc));
         chk($sformatf("v%0d_vld", i), 32'(dlf_vld), 32'd1);
         step();
         chk($sformatf("v%0d_pulse", i), 32'(dlf_vld), 32'd0);
      end

      // Drive from top clamp down to bottom clamp
      restart(16'hFFF0, 4'd0, 4'd0);
      sample(12'h7FF);
      chk("sat_hi_out", 32'(dlf_out), 32'hFFFF);
      for (int i = 0; i < 40; i++) sample(12'h800);
      chk("sat_lo_out", 32'(dlf_out), 32'h0000);
      chk("sat_lo_acc", 32'(dut.acc_q), 32'h000000);

      // Hold freezes output while samples keep arriving
      restart(16'h8000, 4'd2, 4'd6);
      sample(12'h040);
      chk("hold_pre", 32'(dlf_out), 32'h8011);
      csr_hold = 1'b1;
      err = 12'h040;
      err_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_out",   32'(dlf_out),   32'h8011);
         chk("hold_vld",   32'(dlf_vld),   32'd0);
         chk("hold_state", 32'(dlf_state), 32'd3);
      end
      csr_hold = 1'b0;
      step();
      chk("unhold_state", 32'(dlf_state), 32'd1);
      chk("unhold_vld",   32'(dlf_vld),   32'd0);
      step();
      chk("resume_out", 32'(dlf_out), 32'h8012);
      chk("resume_vld", 32'(dlf_vld), 32'd1);
      csr_hold = 1'b1;
      csr_dlf_en = 1'b0;
      csr_init_code = 16'h2345;
      step();
      chk("dis_state", 32'(dlf_state), 32'd0);
      chk("dis_out",   32'(dlf_out),   32'h2345);
      chk("dis_vld",   32'(dlf_vld),   32'd0);

      // Asynchronous reset in the middle of a sample stream
      restart(16'h8000, 4'd2, 4'd6);
      csr_init_code = 16'h1111;
      err = 12'h040;
      err_vld = 1'b1;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out",   32'(dlf_out),   32'h8000);
      chk("arst_state", 32'(dlf_state), 32'd0);
      chk("arst_lock",  32'(lock),      32'd0);
      chk("arst_vld",   32'(dlf_vld),   32'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_state", 32'(dlf_state), 32'd1);
      chk("post_rst_vld",   32'(dlf_vld),   32'd0);
      chk("post_rst_out",   32'(dlf_out),   32'h1111);
      step();
      chk("post_rst_upd", 32'(dlf_vld), 32'd1);
      err_vld = 1'b0;

`ifdef FLB_DLF_LOCK_DET_EN
      restart(16'h8000, 4'd2, 4'd6);
      for (int i = 0; i < 63; i++) sample(12'h001);
      chk("lk63_state", 32'(dlf_state), 32'd1);
      chk("lk63_lock",  32'(lock),      32'd0);
      sample(12'h001);
      chk("lk64_state", 32'(dlf_state), 32'd2);
      chk("lk64_lock",  32'(lock),      32'd1);
      chk("lk64_acc",   32'(dut.acc_q), 32'h800100);
      sample(12'h010);
      chk("trk16_state", 32'(dlf_state), 32'd2);
      chk("trk16_lock",  32'(lock),      32'd1);
      chk("trk16_acc",   32'(dut.acc_q), 32'h800110);
      chk("trk16_out",   32'(dlf_out),   32'h8002);
      sample(12'h011);
      chk("trk17_state", 32'(dlf_state), 32'd1);
      chk("trk17_lock",  32'(lock),      32'd0);
      chk("trk17_acc",   32'(dut.acc_q), 32'h800121);
`else
      restart(16'h8000, 4'd2, 4'd6);
      for (int i = 0; i < 200; i++) begin
         sample(12'h000);
         chk("nolk_state", 32'(dlf_state), 32'd1);
         chk("nolk_lock",  32'(lock),      32'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
